hir_arith_pipe: RTL and testbench

//   Parametrised, statically scheduled integer arithmetic unit for HIR-generated datapaths.

---
 rtl/hir_arith_pipe_if.sv | 25 ++
 rtl/hir_arith_pipe.sv | 118 +++++++++++
 tb/tb_hir_arith_pipe.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hir_arith_pipe_if.sv
// rtl/hir_arith_pipe_if.sv - issue/result bundle for the HIR arithmetic pipe
interface hir_arith_pipe_if #(
  parameter int WIDTH = 32
);
  logic             tstart;
  logic [1:0]       op;
  logic             acc_clr;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] out;
  logic             tdone;
  logic [WIDTH-1:0] acc;

  // Scheduler side: issues ops, observes results
  modport master (
    output tstart, op, acc_clr, in1, in2,
    input  out, tdone, acc
  );

  // Arithmetic unit side
  modport slave (
    input  tstart, op, acc_clr, in1, in2,
    output out, tdone, acc
  );
endinterface

// File: rtl/hir_arith_pipe.sv
// rtl/hir_arith_pipe.sv - fixed-latency ADD/SUB/MUL/MAC unit with valid-token pipeline
module hir_arith_pipe #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2
) (
  input logic             clk,
  input logic             rst,
  hir_arith_pipe_if.slave bus
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_MAC = 2'b11;

  // Operands as seen by the final (result-producing) stage
  logic             fin_valid;
  logic [1:0]       fin_op;
  logic             fin_clr;
  logic [WIDTH-1:0] fin_a;
  logic [WIDTH-1:0] fin_b;

  generate
    if (LATENCY == 1) begin : g_direct
      // Single-cycle latency: the output registers load straight from the issue inputs
      assign fin_valid = bus.tstart;
      assign fin_op    = bus.op;
      assign fin_clr   = bus.acc_clr;
      assign fin_a     = bus.in1;
      assign fin_b     = bus.in2;
    end else begin : g_stages
      // LATENCY-1 carry stages ahead of the output registers
      localparam int NS = LATENCY - 1;

      logic [NS-1:0]    valid_q;
      logic [1:0]       op_q  [NS];
      logic             clr_q [NS];
      logic [WIDTH-1:0] a_q   [NS];
      logic [WIDTH-1:0] b_q   [NS];

      // Valid token shift chain; reset drops every op in flight
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= '0;
        end else begin
          valid_q[0] <= bus.tstart;
          for (int k = 1; k < NS; k++) begin
            valid_q[k] <= valid_q[k-1];
          end
        end
      end

      // Operand carry: stage 1 samples only on issue, later stages shift unconditionally
      always_ff @(posedge clk) begin
        if (bus.tstart) begin
          op_q[0]  <= bus.op;
          clr_q[0] <= bus.acc_clr;
          a_q[0]   <= bus.in1;
          b_q[0]   <= bus.in2;
        end
        for (int k = 1; k < NS; k++) begin
          op_q[k]  <= op_q[k-1];
          clr_q[k] <= clr_q[k-1];
          a_q[k]   <= a_q[k-1];
          b_q[k]   <= b_q[k-1];
        end
      end

      assign fin_valid = valid_q[NS-1];
      assign fin_op    = op_q[NS-1];
      assign fin_clr   = clr_q[NS-1];
      assign fin_a     = a_q[NS-1];
      assign fin_b     = b_q[NS-1];
    end
  endgenerate

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             tdone_q;
  logic [WIDTH-1:0] prod;

  // Final-stage arithmetic; MAC resolves here so back-to-back MACs see each other in order
  always_comb begin
    prod  = fin_a * fin_b;
    out_d = out_q;
    acc_d = acc_q;
    if (fin_valid) begin
      case (fin_op)
        OP_ADD:  out_d = fin_a + fin_b;
        OP_SUB:  out_d = fin_a - fin_b;
        OP_MUL:  out_d = prod;
        OP_MAC: begin
          out_d = fin_clr ? prod : (acc_q + prod);
          acc_d = out_d;
        end
        default: out_d = out_q;
      endcase
    end
  end

  // Result, accumulator and completion strobe registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      acc_q   <= '0;
      tdone_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      acc_q   <= acc_d;
      tdone_q <= fin_valid;
    end
  end

  assign bus.out   = out_q;
  assign bus.acc   = acc_q;
  assign bus.tdone = tdone_q;

endmodule

// File: tb/tb_hir_arith_pipe.sv
// tb/tb_hir_arith_pipe.sv - scoreboard bench for three hir_arith_pipe configurations
module tb_hir_arith_pipe;

  typedef struct {
    logic [31:0] val;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        drv_tstart;
  logic [1:0]  drv_op;
  logic        drv_clr;
  logic [31:0] drv_a;
  logic [31:0] drv_b;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  exp_t q32[$];
  exp_t q1[$];
  exp_t q4[$];
  logic [31:0] m_acc32 = '0;
  logic [31:0] m_acc1  = '0;
  logic [31:0] m_acc4  = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hir_arith_pipe_if #(.WIDTH(32)) b32 ();
  hir_arith_pipe_if #(.WIDTH(8))  b1 ();
  hir_arith_pipe_if #(.WIDTH(8))  b4 ();

  assign b32.tstart = drv_tstart;
  assign b32.op     = drv_op;
  assign b32.acc_clr = drv_clr;
  assign b32.in1    = drv_a;
  assign b32.in2    = drv_b;
  assign b1.tstart  = drv_tstart;
  assign b1.op      = drv_op;
  assign b1.acc_clr = drv_clr;
  assign b1.in1     = drv_a[7:0];
  assign b1.in2     = drv_b[7:0];
  assign b4.tstart  = drv_tstart;
  assign b4.op      = drv_op;
  assign b4.acc_clr = drv_clr;
  assign b4.in1     = drv_a[7:0];
  assign b4.in2     = drv_b[7:0];

  hir_arith_pipe #(.WIDTH(32), .LATENCY(2)) u32 (.clk(clk), .rst(rst), .bus(b32));
  hir_arith_pipe #(.WIDTH(8),  .LATENCY(1)) u1  (.clk(clk), .rst(rst), .bus(b1));
  hir_arith_pipe #(.WIDTH(8),  .LATENCY(4)) u4  (.clk(clk), .rst(rst), .bus(b4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic clr,
                                        input logic [31:0] mask, inout logic [31:0] acc);
    logic [31:0] r;
    case (op)
      2'b00:   r = a + b;
      2'b01:   r = a - b;
      2'b10:   r = a * b;
      default: r = clr ? (a * b) : (acc + a * b);
    endcase
    r = r & mask;
    if (op == 2'b11) acc = r;
    return r;
  endfunction

  // Drive one issue for the coming edge and record the expected result per configuration
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic clr);
    exp_t e;
    drv_tstart = 1'b1;
    drv_op     = op;
    drv_a      = a;
    drv_b      = b;
    drv_clr    = clr;
    e.val = model(op, a, b, clr, 32'hFFFF_FFFF, m_acc32); e.due = cyc + 2; q32.push_back(e);
    e.val = model(op, a, b, clr, 32'h0000_00FF, m_acc1);  e.due = cyc + 1; q1.push_back(e);
    e.val = model(op, a, b, clr, 32'h0000_00FF, m_acc4);  e.due = cyc + 4; q4.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    drv_tstart = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    drv_tstart = 1'b0;
    n = 0;
    while ((q32.size() + q1.size() + q4.size()) != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain_q32_empty", q32.size(), 0);
    check("drain_q1_empty",  q1.size(),  0);
    check("drain_q4_empty",  q4.size(),  0);
  endtask

  task automatic flush_model();
    q32.delete(); q1.delete(); q4.delete();
    m_acc32 = '0; m_acc1 = '0; m_acc4 = '0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out32"},   b32.out,   0);
    check({tag, "_tdone32"}, b32.tdone, 0);
    check({tag, "_acc32"},   b32.acc,   0);
    check({tag, "_out1"},    b1.out,    0);
    check({tag, "_tdone1"},  b1.tdone,  0);
    check({tag, "_acc1"},    b1.acc,    0);
    check({tag, "_out4"},    b4.out,    0);
    check({tag, "_tdone4"},  b4.tdone,  0);
    check({tag, "_acc4"},    b4.acc,    0);
  endtask

  // Scoreboard pop for WIDTH=32, LATENCY=2
  always @(negedge clk) begin
    if (!rst && b32.tdone === 1'b1) begin
      if (q32.size() == 0) begin
        check("w32l2_unexpected_tdone", 1, 0);
      end else begin
        exp_t e;
        e = q32.pop_front();
        check("w32l2_out", b32.out, e.val);
        check("w32l2_latency", cyc, e.due);
      end
    end
  end

  // Scoreboard pop for WIDTH=8, LATENCY=1
  always @(negedge clk) begin
    if (!rst && b1.tdone === 1'b1) begin
      if (q1.size() == 0) begin
        check("w8l1_unexpected_tdone", 1, 0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("w8l1_out", {24'h0, b1.out}, e.val);
        check("w8l1_latency", cyc, e.due);
      end
    end
  end

  // Scoreboard pop for WIDTH=8, LATENCY=4
  always @(negedge clk) begin
    if (!rst && b4.tdone === 1'b1) begin
      if (q4.size() == 0) begin
        check("w8l4_unexpected_tdone", 1, 0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        check("w8l4_out", {24'h0, b4.out}, e.val);
        check("w8l4_latency", cyc, e.due);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    drv_tstart = 1'b0;
    drv_op     = 2'b00;
    drv_clr    = 1'b0;
    drv_a      = '0;
    drv_b      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Single ADD, then wraps and truncations
    issue(2'b00, 32'd5, 32'd7, 1'b0);
    drain();
    issue(2'b01, 32'd3, 32'd5, 1'b0);
    issue(2'b10, 32'h0001_0000, 32'h0001_0000, 1'b0);
    issue(2'b10, 32'hFFFF_FFFF, 32'd2, 1'b0);
    issue(2'b00, 32'h0000_00FF, 32'h0000_0002, 1'b0);
    idle();
    drain();

    // Back-to-back mix
    issue(2'b00, 32'd1, 32'd1, 1'b0);
    issue(2'b10, 32'd3, 32'd4, 1'b0);
    issue(2'b01, 32'd9, 32'd2, 1'b0);
    issue(2'b00, 32'd0, 32'd0, 1'b0);
    drain();

    // MAC chain with an ADD interleaved
    issue(2'b11, 32'd2, 32'd3, 1'b1);
    issue(2'b11, 32'd4, 32'd5, 1'b0);
    issue(2'b00, 32'd7, 32'd8, 1'b0);
    issue(2'b11, 32'd1, 32'd1, 1'b0);
    drain();
    check("mac_acc32", b32.acc, 32'd27);
    check("mac_acc1",  b1.acc,  8'd27);
    check("mac_acc4",  b4.acc,  8'd27);

    // Reset one cycle after issue drops the op (except where it already completed)
    issue(2'b10, 32'd6, 32'd7, 1'b0);
    drv_tstart = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    flush_model();
    @(negedge clk);
    rst = 1'b0;
    check_zero("rst_inflight");
    repeat (6) @(negedge clk);
    check("rst_q32_no_tdone", q32.size(), 0);

    // Op issued in the same cycle as reset is dropped
    rst = 1'b1;
    issue(2'b00, 32'd1, 32'd2, 1'b0);
    flush_model();
    rst = 1'b0;
    drv_tstart = 1'b0;
    repeat (6) @(negedge clk);
    check_zero("rst_same_cycle");

    // Normal completion after reset
    issue(2'b00, 32'd5, 32'd7, 1'b0);
    drain();

    // Random back-to-back traffic
    for (int i = 0; i < 24; i++) begin
      issue(2'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom_range(0, 1)));
    end
    drain();
    check("rand_acc32", b32.acc, m_acc32);
    check("rand_acc1",  {24'h0, b1.acc}, m_acc1);
    check("rand_acc4",  {24'h0, b4.acc}, m_acc4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
